// File: rtl/dram_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dram_arbiter_if
// Purpose  : CPU data port, auxiliary port and data RAM port of dram_arbiter
// Revision : 1.0 - initial release
// ============================================================================
interface dram_arbiter_if #(
  parameter int AW = 24,
  parameter int DW = 32
);
  logic          i_cpu_req;
  logic          i_cpu_wr;
  logic [AW-1:0] i_cpu_addr;
  logic [DW-1:0] i_cpu_din;
  logic [DW-1:0] o_cpu_dout;
  logic          o_cpu_stall;

  logic          i_aux_req;
  logic          i_aux_wr;
  logic [AW-1:0] i_aux_addr;
  logic [DW-1:0] i_aux_wdata;
  logic          o_aux_ack;
  logic [DW-1:0] o_aux_rdata;

  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] o_ram_din;
  logic          o_ram_wr;
  logic [DW-1:0] i_ram_dout;

  // Arbiter side
  modport slave (
    input  i_cpu_req, i_cpu_wr, i_cpu_addr, i_cpu_din,
    output o_cpu_dout, o_cpu_stall,
    input  i_aux_req, i_aux_wr, i_aux_addr, i_aux_wdata,
    output o_aux_ack, o_aux_rdata,
    output o_ram_addr, o_ram_din, o_ram_wr,
    input  i_ram_dout
  );

  // Requesters and RAM side
  modport master (
    output i_cpu_req, i_cpu_wr, i_cpu_addr, i_cpu_din,
    input  o_cpu_dout, o_cpu_stall,
    output i_aux_req, i_aux_wr, i_aux_addr, i_aux_wdata,
    input  o_aux_ack, o_aux_rdata,
    input  o_ram_addr, o_ram_din, o_ram_wr,
    output i_ram_dout
  );
endinterface
`default_nettype wire

// File: rtl/dram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dram_arbiter
// Purpose  : CPU-priority arbiter for the single-port data RAM with a
//            bounded-wait forced grant for the auxiliary requester
// Revision : 1.0 - initial release
// ============================================================================
module dram_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int AW       = 24,
  parameter int DW       = 32
) (
  input  wire logic      i_clk,
  input  wire logic      i_rst,
  input  wire logic      i_clk_en,
  dram_arbiter_if.slave  bus
);

  localparam logic [1:0] A_IDLE     = 2'd0;
  localparam logic [1:0] A_WAIT     = 2'd1;
  localparam logic [1:0] A_ACK      = 2'd2;
  localparam logic       OWN_CPU    = 1'b0;
  localparam logic       OWN_AUX    = 1'b1;
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  logic [1:0]    state_q, state_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic          ack_q;
  logic          owner_q;
  logic          aux_wr_q;
  logic [DW-1:0] aux_rdata_q;

  logic          w_aux_pending;
  logic          w_aux_grant;
  logic          w_owner_wr;
  logic [AW-1:0] w_ram_addr;

  // No auxiliary grant in A_ACK: the stalled CPU access must win that cycle.
  assign w_aux_pending = bus.i_aux_req && (state_q != A_ACK);
  assign w_aux_grant   = w_aux_pending &&
                         (!bus.i_cpu_req || (wait_cnt_q == WAIT_LIMIT));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      A_IDLE, A_WAIT: begin
        if (w_aux_grant) begin
          state_d    = A_ACK;
          wait_cnt_d = 8'd0;
        end else if (bus.i_aux_req) begin
          state_d    = A_WAIT;
          wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
        end else begin
          state_d    = A_IDLE;
          wait_cnt_d = 8'd0;
        end
      end
      A_ACK: begin
        state_d    = A_IDLE;
        wait_cnt_d = 8'd0;
      end
      default: begin
        state_d    = A_IDLE;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  assign w_ram_addr      = w_aux_grant ? bus.i_aux_addr : bus.i_cpu_addr;
  assign w_owner_wr      = w_aux_grant ? bus.i_aux_wr : (bus.i_cpu_req && bus.i_cpu_wr);

  assign bus.o_ram_addr  = w_ram_addr;
  assign bus.o_ram_din   = w_aux_grant ? bus.i_aux_wdata : bus.i_cpu_din;
  assign bus.o_ram_wr    = i_clk_en && !i_rst && w_owner_wr;
  assign bus.o_cpu_stall = !i_rst && bus.i_cpu_req && w_aux_grant;
  assign bus.o_cpu_dout  = bus.i_ram_dout;
  assign bus.o_aux_ack   = ack_q;

  // RAM data arrives during the ack cycle; the register keeps it afterwards.
  assign bus.o_aux_rdata = (ack_q && (owner_q == OWN_AUX) && !aux_wr_q) ?
                           bus.i_ram_dout : aux_rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= A_IDLE;
      wait_cnt_q  <= 8'd0;
      ack_q       <= 1'b0;
      owner_q     <= OWN_CPU;
      aux_wr_q    <= 1'b0;
      aux_rdata_q <= '0;
    end else if (i_clk_en) begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ack_q      <= w_aux_grant;
      owner_q    <= w_aux_grant ? OWN_AUX : OWN_CPU;
      if (w_aux_grant) begin
        aux_wr_q <= bus.i_aux_wr;
      end
      if ((state_q == A_ACK) && (owner_q == OWN_AUX) && !aux_wr_q) begin
        aux_rdata_q <= bus.i_ram_dout;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/dram_arbiter.md
# dram_arbiter

Shares the single-port synchronous data RAM between the CPU data port and one auxiliary requester (program loader, debug/DMA engine). The CPU has priority. A bounded-wait counter guarantees the auxiliary port forward progress by stalling the CPU for exactly one cycle when the limit is reached. The block sits between the CPU data bus and the data RAM inside the system top level.

## Interface
- `MAX_WAIT`, default 4: consecutive denied auxiliary cycles before a forced auxiliary grant. Legal range 0–255; 0 gives the auxiliary port absolute priority.
- `AW`, default 24: word address width.
- `DW`, default 32: data width.

Ports:
- `i_clk` in 1: single clock; all state changes on its rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_clk_en` in 1: when low, no state changes and `o_ram_wr` is forced to 0.
- `i_cpu_req` in 1: CPU access request, valid for one cycle unless stalled.
- `i_cpu_wr` in 1: CPU write (1) or read (0).
- `i_cpu_addr` in AW: CPU address.
- `i_cpu_din` in DW: CPU write data.
- `o_cpu_dout` out DW: CPU read data, equal to `i_ram_dout`.
- `o_cpu_stall` out 1: CPU access not taken this cycle; CPU holds its request.
- `i_aux_req` in 1: auxiliary request, held high until `o_aux_ack`.
- `i_aux_wr` in 1: auxiliary write (1) or read (0).
- `i_aux_addr` in AW: auxiliary address.
- `i_aux_wdata` in DW: auxiliary write data.
- `o_aux_ack` out 1: one-cycle pulse marking auxiliary access complete.
- `o_aux_rdata` out DW: auxiliary read data, registered, valid while `o_aux_ack` is high.
- `o_ram_addr` out AW, `o_ram_din` out DW, `o_ram_wr` out 1: RAM port.
- `i_ram_dout` in DW: RAM read data, valid one cycle after the address.

## Operation
Auxiliary FSM states:
- **A_IDLE**: `i_aux_req` moves the FSM to A_WAIT in the same cycle. The grant is evaluated combinationally in that same cycle.
- **A_WAIT**: auxiliary request pending.
- **A_ACK**: granted last cycle; `o_aux_ack` is high. No auxiliary grant is allowed in this state. Next state is always A_IDLE.

Grant rule, evaluated in A_IDLE or A_WAIT with `i_aux_req` = 1:
- `aux_grant = !i_cpu_req || (wait_cnt == MAX_WAIT)`.
- On `aux_grant`: the RAM port is driven from the auxiliary inputs, `wait_cnt` clears to 0, and the next state is A_ACK.
- Otherwise the CPU owns the port, `wait_cnt` increments (8 bits, saturating at 255), and the next state is A_WAIT.

Other ownership rules:
- `o_cpu_stall = i_cpu_req && aux_grant`. A stalled CPU re-presents the same access the next cycle. That cycle is A_ACK, so the CPU is guaranteed to win.
- When the CPU owns the port, the RAM inputs follow the CPU inputs.
- When there is no request, `o_ram_wr` = 0 and the address and data follow the CPU inputs.
- `o_ram_wr = i_clk_en && !i_rst && (owner write)`.

Read data:
- A registered `owner_q` records which port owned the RAM in the previous cycle.
- `o_aux_rdata` captures `i_ram_dout` in A_ACK.
- `o_cpu_dout` is a pass-through of `i_ram_dout`; the CPU samples it only after an unstalled read.

Other rules:
- A write ack carries `o_aux_rdata` unchanged.
- If `i_aux_req` drops while in A_WAIT (protocol violation), return to A_IDLE and clear `wait_cnt`.

## Timing
- Reset values: state A_IDLE, `wait_cnt` 0, `o_aux_ack` 0, `o_aux_rdata` 0, `owner_q` CPU.
- While `i_rst` is high: `o_cpu_stall` 0 and `o_ram_wr` 0.
- Reset asserted mid-transaction drops any pending auxiliary grant with no ack. The auxiliary requester must re-request.
- CPU latency: 0 added cycles when unstalled. Read data appears in cycle N+1 for a request in cycle N.
- Auxiliary latency: grant in cycle G, ack and data in G+1. Minimum request-to-ack is 1 cycle; maximum is MAX_WAIT+1 cycles under continuous CPU traffic.
- Auxiliary throughput: at most one access per 2 cycles. A new request may be presented in the cycle after the ack.
- Simultaneous requests with `wait_cnt` < MAX_WAIT: the CPU wins.
- With `i_clk_en` = 0: all registers hold, `o_aux_ack` holds its value, and no RAM write occurs.

## Test plan
- **Reset**: hold `i_rst` 3 cycles with both requests high → `o_ram_wr` 0, `o_cpu_stall` 0, `o_aux_ack` 0. After release, the first auxiliary ack occurs no earlier than 1 cycle after the grant.
- **CPU only**: CPU writes 0xDEADBEEF to 0x000010, then reads 0x000010 → `o_ram_wr` pulses for 1 cycle, never stalls, and `o_cpu_dout` = 0xDEADBEEF in the cycle after the read.
- **Auxiliary on idle bus**: aux reads 0x000010 with CPU idle → `o_aux_ack` in the cycle after the request, `o_aux_rdata` = 0xDEADBEEF, `o_aux_ack` high for exactly 1 cycle.
- **Starvation**: MAX_WAIT=4, CPU requests every cycle, aux requests at cycle 0 → CPU wins cycles 0–3, aux is granted at cycle 4 with `o_cpu_stall`=1 for that single cycle, ack at cycle 5, and the CPU's held access completes at cycle 5.
- **Reset mid-wait**: aux pending with `wait_cnt`=2, then `i_rst` pulsed → no ack, `wait_cnt` 0. A re-request under continuous CPU traffic is granted after 4 denied cycles.
- **Clock enable**: drop `i_clk_en` for 3 cycles during A_ACK → `o_aux_ack` and state are held, `o_ram_wr` stays 0, and operation resumes correctly when `i_clk_en` returns high.
